status_link_scheduler: RTL and testbench

// - Shares the single serial status channel to the keyboard unit (STATUS_OUT/STATUS_SEND) between three requesters.
// - Requesters: alarm-event (urgent), FSM state report, key-check feedback.
// - Frames one granted 4-bit message per slot and inserts the stand-by gap.
// - Retransmits the last message as a heartbeat when the link is idle.
// - Sits between the main alarm FSM and the status pins; replaces the free-running serial transmitter.

---
 rtl/alarm_pkg.sv | 30 +++
 rtl/status_frame_shifter.sv | 30 +++
 rtl/status_link_scheduler.sv | 163 ++++++++++++++++
 tb/tb_status_link_scheduler.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared definitions for the status link scheduler: link FSM states,
// requester indices and the default message width.
package alarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } link_state_e;

    localparam logic [1:0] SRC_ALARM = 2'd0;
    localparam logic [1:0] SRC_STATE = 2'd1;
    localparam logic [1:0] SRC_KEY   = 2'd2;
    localparam logic [1:0] SRC_HB    = 2'd3;

    localparam int unsigned MSG_W_DEF = 4;

    // One-hot grant vector for a source index; the heartbeat grants nobody.
    function automatic logic [2:0] src_onehot(input logic [1:0] src);
        logic [2:0] oh;
        case (src)
            SRC_ALARM: oh = 3'b001;
            SRC_STATE: oh = 3'b010;
            SRC_KEY:   oh = 3'b100;
            default:   oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/status_frame_shifter.sv
// Parallel-in / serial-out frame register, MSB first.
module status_frame_shifter
    import alarm_pkg::*;
#(
    parameter int unsigned MSG_W = MSG_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [MSG_W-1:0] data_i,
    output logic             ser_o
);

    logic [MSG_W-1:0] sreg_q;

    // Load a new message or move the next bit into the MSB position.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sreg_q <= '0;
        end else if (load_i) begin
            sreg_q <= data_i;
        end else if (shift_i) begin
            sreg_q <= sreg_q << 1;
        end
    end

    assign ser_o = sreg_q[MSG_W-1];

endmodule

// File: rtl/status_link_scheduler.sv
// Shares the serial status channel between the alarm, state-report and
// key-feedback requesters, framing one message per slot with a stand-by gap
// and resending the last message as a heartbeat when the link stays idle.
module status_link_scheduler
    import alarm_pkg::*;
#(
    parameter int unsigned MSG_W   = MSG_W_DEF,
    parameter int unsigned SB      = 3,
    parameter int unsigned REFRESH = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [2:0]         REQ,
    input  logic [3*MSG_W-1:0] MSG_IN,
    output logic [2:0]         GRANT,
    output logic               BUSY,
    output logic               STATUS_OUT,
    output logic               STATUS_SEND,
    output logic [1:0]         LAST_SRC
);

    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(MSG_W - 1);
    localparam logic [CNT_W-1:0] LAST_GAP  = CNT_W'((SB == 0) ? 0 : SB - 1);
    localparam logic [CNT_W-1:0] LAST_IDLE = CNT_W'((REFRESH == 0) ? 0 : REFRESH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam bit               HB_EN     = (REFRESH != 0);
    localparam bit               HAS_GAP   = (SB != 0);

    link_state_e      state_q;
    logic [CNT_W-1:0] phase_q;
    logic [CNT_W-1:0] idle_q;
    logic [MSG_W-1:0] last_msg_q;
    logic [1:0]       ptr_q;
    logic [1:0]       last_src_q;
    logic [2:0]       grant_q;
    logic             busy_q;
    logic             sout_q;
    logic             ssend_q;

    logic             any_req;
    logic             hb_fire;
    logic             start;
    logic             shift_en;
    logic             ser;
    logic [1:0]       win_src;
    logic [MSG_W-1:0] win_msg;
    logic [MSG_W-1:0] load_msg;

    // Arbitration and frame-start decision for the current IDLE cycle.
    always_comb begin
        any_req = |REQ;
        win_src = SRC_STATE;
        if (REQ[0]) begin
            win_src = SRC_ALARM;
        end else if (REQ[1] && REQ[2]) begin
            win_src = ptr_q;
        end else if (REQ[2]) begin
            win_src = SRC_KEY;
        end
        case (win_src)
            SRC_ALARM: win_msg = MSG_IN[0 +: MSG_W];
            SRC_STATE: win_msg = MSG_IN[MSG_W +: MSG_W];
            default:   win_msg = MSG_IN[2*MSG_W +: MSG_W];
        endcase
        hb_fire  = HB_EN && !any_req && (idle_q == LAST_IDLE);
        start    = (state_q == ST_IDLE) && (any_req || hb_fire);
        load_msg = any_req ? win_msg : last_msg_q;
        shift_en = (state_q == ST_SEND);
    end

    status_frame_shifter #(
        .MSG_W (MSG_W)
    ) u_shifter (
        .clk_i   (CLK),
        .rst_i   (RST),
        .load_i  (start),
        .shift_i (shift_en),
        .data_i  (load_msg),
        .ser_o   (ser)
    );

    // Link FSM; pin outputs are registered so they trail the state by one
    // cycle, which is why BUSY stays high through the IDLE cycle after GAP.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            phase_q    <= '0;
            idle_q     <= '0;
            last_msg_q <= '0;
            ptr_q      <= SRC_STATE;
            last_src_q <= SRC_HB;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            sout_q     <= 1'b0;
            ssend_q    <= 1'b0;
        end else begin
            grant_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    ssend_q <= 1'b0;
                    sout_q  <= 1'b0;
                    if (start) begin
                        state_q <= ST_SEND;
                        phase_q <= '0;
                        idle_q  <= '0;
                        busy_q  <= 1'b1;
                        if (any_req) begin
                            grant_q    <= src_onehot(win_src);
                            last_src_q <= win_src;
                            last_msg_q <= win_msg;
                            if (win_src != SRC_ALARM) begin
                                ptr_q <= (win_src == SRC_STATE) ? SRC_KEY : SRC_STATE;
                            end
                        end else begin
                            last_src_q <= SRC_HB;
                        end
                    end else begin
                        busy_q <= 1'b0;
                        if (HB_EN) begin
                            idle_q <= idle_q + CNT_ONE;
                        end
                    end
                end
                ST_SEND: begin
                    ssend_q <= 1'b1;
                    sout_q  <= ser;
                    busy_q  <= 1'b1;
                    if (phase_q == LAST_BIT) begin
                        phase_q <= '0;
                        state_q <= HAS_GAP ? ST_GAP : ST_IDLE;
                    end else begin
                        phase_q <= phase_q + CNT_ONE;
                    end
                end
                ST_GAP: begin
                    ssend_q <= 1'b0;
                    sout_q  <= 1'b0;
                    busy_q  <= 1'b1;
                    if (phase_q == LAST_GAP) begin
                        phase_q <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        phase_q <= phase_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    ssend_q <= 1'b0;
                    sout_q  <= 1'b0;
                end
            endcase
        end
    end

    assign GRANT       = grant_q;
    assign BUSY        = busy_q;
    assign STATUS_OUT  = sout_q;
    assign STATUS_SEND = ssend_q;
    assign LAST_SRC    = last_src_q;

endmodule

// File: tb/tb_status_link_scheduler.sv
// Bench for status_link_scheduler: frame-level reference model checked every
// cycle, directed scenarios with literal expectations, then random requesters.
module tb_status_link_scheduler;

    localparam int MSG_W   = 4;
    localparam int SB      = 3;
    localparam int REFRESH = 16;

    logic        CLK = 1'b0;
    logic        RST;
    logic [2:0]  req;
    logic [11:0] msg;
    logic [2:0]  grant;
    logic        busy, sout, ssend;
    logic [1:0]  last_src;

    logic [2:0]  req0;
    logic [11:0] msg0;
    logic [2:0]  grant0;
    logic        busy0, sout0, ssend0;
    logic [1:0]  last_src0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    status_link_scheduler #(
        .MSG_W   (MSG_W),
        .SB      (SB),
        .REFRESH (REFRESH),
        .CNT_W   (8)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .REQ         (req),
        .MSG_IN      (msg),
        .GRANT       (grant),
        .BUSY        (busy),
        .STATUS_OUT  (sout),
        .STATUS_SEND (ssend),
        .LAST_SRC    (last_src)
    );

    status_link_scheduler #(
        .MSG_W   (MSG_W),
        .SB      (SB),
        .REFRESH (0),
        .CNT_W   (8)
    ) dut_nohb (
        .CLK         (CLK),
        .RST         (RST),
        .REQ         (req0),
        .MSG_IN      (msg0),
        .GRANT       (grant0),
        .BUSY        (busy0),
        .STATUS_OUT  (sout0),
        .STATUS_SEND (ssend0),
        .LAST_SRC    (last_src0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] get_msg(input logic [11:0] m, input int s);
        case (s)
            0:       return m[3:0];
            1:       return m[7:4];
            default: return m[11:8];
        endcase
    endfunction

    function automatic logic [11:0] put_msg(input logic [11:0] m, input int s, input logic [3:0] v);
        logic [11:0] r;
        r = m;
        case (s)
            0:       r[3:0]  = v;
            1:       r[7:4]  = v;
            default: r[11:8] = v;
        endcase
        return r;
    endfunction

    // ---------------- frame-level reference model ----------------
    // A frame started at edge fs owns the pins for edges fs..fs+MSG_W+SB:
    // grant after fs, data bits after fs+1..fs+MSG_W, next arbitration at
    // edge fs+1+MSG_W+SB.
    int         cyc      = 0;
    int         fs       = 0;
    int         free_at  = 0;
    int         idle_cnt = 0;
    int         ptr      = 1;
    int         m_src    = 3;
    bit         m_valid  = 1'b0;
    bit         has_fr   = 1'b0;
    logic [3:0] last_msg = '0;
    logic [3:0] fr_msg   = '0;
    logic [2:0] fr_grant = '0;

    always @(posedge CLK) begin
        int w;
        cyc++;
        if (RST) begin
            m_valid  = 1'b1;
            has_fr   = 1'b0;
            free_at  = cyc + 1;
            idle_cnt = 0;
            ptr      = 1;
            last_msg = '0;
            m_src    = 3;
        end else if (m_valid && cyc >= free_at) begin
            if (req != 3'b000) begin
                if (req[0])                w = 0;
                else if (req[1] && req[2]) w = ptr;
                else if (req[1])           w = 1;
                else                       w = 2;
                fr_msg   = get_msg(msg, w);
                fr_grant = 3'(1 << w);
                last_msg = fr_msg;
                m_src    = w;
                if (w != 0) ptr = 3 - w;
                fs = cyc; has_fr = 1'b1; free_at = cyc + 1 + MSG_W + SB; idle_cnt = 0;
            end else if (REFRESH > 0 && idle_cnt == REFRESH - 1) begin
                fr_msg   = last_msg;
                fr_grant = 3'b000;
                m_src    = 3;
                fs = cyc; has_fr = 1'b1; free_at = cyc + 1 + MSG_W + SB; idle_cnt = 0;
            end else begin
                idle_cnt++;
            end
        end
    end

    // Compare every cycle once the model has seen reset.
    always @(negedge CLK) begin
        logic [2:0] e_grant;
        logic       e_busy, e_out, e_send;
        int         d;
        if (m_valid) begin
            e_grant = '0; e_busy = 1'b0; e_out = 1'b0; e_send = 1'b0;
            if (has_fr) begin
                d = cyc - fs;
                if (d == 0) e_grant = fr_grant;
                if (d >= 0 && d <= MSG_W + SB) e_busy = 1'b1;
                if (d >= 1 && d <= MSG_W) begin
                    e_send = 1'b1;
                    e_out  = fr_msg[MSG_W - d];
                end
            end
            check($sformatf("model_cyc%0d {grant,busy,out,send,last}", cyc),
                  {grant, busy, sout, ssend, last_src},
                  {e_grant, e_busy, e_out, e_send, 2'(m_src)});
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 60) begin
            @(negedge CLK);
            n++;
        end
        if (busy !== 1'b0) check("wait_idle_timeout BUSY", 32'(busy), 32'd0);
    endtask

    task automatic wait_grant(output logic [2:0] g, output int n);
        g = '0;
        n = 0;
        while (g == 3'b000 && n < 40) begin
            @(negedge CLK);
            n++;
            g = grant;
        end
        if (g == 3'b000) check("wait_grant_timeout GRANT", 32'(g), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int         hb_at, n, ng, cnt;
        bit         saw_g;
        logic [3:0] data;
        logic [2:0] g;
        logic [2:0] gseq [4];
        int         gt [4];
        int         mode;
        int         p;

        RST = 1'b1; req = '0; msg = '0; req0 = '0; msg0 = '0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;

        // Heartbeat after reset: first STATUS_SEND after the 17th edge.
        hb_at = 0; saw_g = 1'b0;
        for (int k = 1; k <= 40 && hb_at == 0; k++) begin
            @(negedge CLK);
            if (grant != 3'b000) saw_g = 1'b1;
            if (ssend) hb_at = k;
        end
        check("hb_first_send_edge", 32'(hb_at), 32'd17);
        check("hb_last_src", 32'(last_src), 32'd3);
        data = '0; cnt = 0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge CLK);
            data = {data[2:0], sout};
            if (ssend) cnt++;
            if (grant != 3'b000) saw_g = 1'b1;
        end
        check("hb_frame {sends,data}", {cnt[2:0], data}, {3'd4, 4'b0000});
        check("hb_no_grant", 32'(saw_g), 32'd0);

        // Single alarm request 1011.
        wait_idle();
        req = 3'b001; msg = put_msg(msg, 0, 4'b1011);
        @(negedge CLK);
        check("alarm_grant", 32'(grant), 32'b001);
        req = 3'b000;
        data = '0; cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            data = {data[2:0], sout};
            if (ssend) cnt++;
        end
        check("alarm_frame {sends,data}", {cnt[2:0], data}, {3'd4, 4'b1011});
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            if (busy && !ssend) cnt++;
        end
        check("alarm_gap_cycles", 32'(cnt), 32'd3);
        @(negedge CLK);
        check("alarm_busy_after_gap", 32'(busy), 32'd0);

        // Sources 1 and 2 held together: alternate with period 8.
        wait_idle();
        req = 3'b110; msg = put_msg(msg, 1, 4'b0011); msg = put_msg(msg, 2, 4'b1100);
        ng = 0;
        for (int c = 0; c < 60 && ng < 4; c++) begin
            @(negedge CLK);
            if (grant != 3'b000) begin
                gseq[ng] = grant; gt[ng] = c; ng++;
                if (ng == 4) req = 3'b000;
            end
        end
        if (ng < 4) begin
            for (int k = ng; k < 4; k++) begin gseq[k] = '0; gt[k] = 0; end
        end
        check("rr_sequence", {gseq[0], gseq[1], gseq[2], gseq[3]}, 12'b010_100_010_100);
        check("rr_period_x3", 32'(gt[3] - gt[0]), 32'd24);

        // Alarm arrives during source 1's frame; key request pending too.
        wait_idle();
        req = 3'b110;
        wait_grant(g, n);
        check("pre_grant_state", 32'(g), 32'b010);
        req[1] = 1'b0;
        @(negedge CLK);
        req[0] = 1'b1; msg = put_msg(msg, 0, 4'b0110);
        wait_grant(g, n);
        check("urgent_after_frame {grant,wait}", {g, n[7:0]}, {3'b001, 8'd7});
        req[0] = 1'b0;
        wait_grant(g, n);
        check("key_after_alarm", 32'(g), 32'b100);
        req = 3'b000;

        // Reset in the middle of a frame.
        wait_idle();
        req = 3'b010; msg = put_msg(msg, 1, 4'b1001);
        wait_grant(g, n);
        check("rst_test_grant", 32'(g), 32'b010);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check("rst_mid_frame {grant,send,busy,last}", {grant, ssend, busy, last_src},
              {3'b000, 1'b0, 1'b0, 2'd3});
        RST = 1'b0;
        @(negedge CLK);
        check("grant_after_rst", 32'(grant), 32'b010);
        req = 3'b000;

        // Random requesters with withdrawals and quiet spells.
        mode = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge CLK);
            if (c % 250 == 0) mode = $urandom_range(0, 2);
            for (int i = 0; i < 3; i++) begin
                if (req[i]) begin
                    if (grant[i]) req[i] = 1'b0;
                    else if ($urandom_range(0, 99) < 2) req[i] = 1'b0;
                end else begin
                    p = (mode == 0) ? 0 : (mode == 1) ? 4 : 35;
                    if (i == 0) p = p / 3;
                    if ($urandom_range(0, 99) < p) begin
                        req[i] = 1'b1;
                        msg    = put_msg(msg, i, 4'($urandom));
                    end
                end
            end
        end
        req = 3'b000;

        // Heartbeat disabled instance: silent when idle, one frame per request.
        cnt = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge CLK);
            if (ssend0 || busy0 || grant0 != 3'b000) cnt++;
        end
        check("nohb_idle_activity", 32'(cnt), 32'd0);
        req0 = 3'b100; msg0 = put_msg(msg0, 2, 4'b1101);
        g = '0;
        for (int c = 0; c < 40 && g == 3'b000; c++) begin
            @(negedge CLK);
            g = grant0;
        end
        check("nohb_grant", 32'(g), 32'b100);
        req0 = 3'b000;
        data = '0; cnt = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge CLK);
            if (ssend0) begin
                cnt++;
                data = {data[2:0], sout0};
            end
        end
        check("nohb_single_frame {sends,data}", {cnt[7:0], data}, {8'd4, 4'b1101});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
